// File: rtl/stall_ctrl.sv
// Pipeline hazard detection for the D stage plus the HI/LO multiply/divide busy tracker.
// Stall outputs are purely combinational; only the busy counter is registered.
module stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_Tuse_rs,
  input  logic [1:0] D_Tuse_rt,
  input  logic       D_md,
  input  logic [4:0] E_A3,
  input  logic [1:0] E_Tnew,
  input  logic [4:0] M_A3,
  input  logic [1:0] M_Tnew,
  input  logic       E_start,
  input  logic       E_div,
  output logic       stall,
  output logic       pc_en,
  output logic       D_en,
  output logic       E_flush,
  output logic       busy,
  output logic       md_done
);

  localparam logic [3:0] MultLoad = 4'(MULT_CYCLES);
  localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES);

  logic [3:0] cnt_q, cnt_d;
  logic       stall_rs, stall_rt, stall_md;

  // A source operand stalls only if a later stage will not have its value ready in time.
  always_comb begin
    stall_rs = (D_rs != 5'd0) &&
               (((E_A3 == D_rs) && (E_Tnew > D_Tuse_rs)) ||
                ((M_A3 == D_rs) && (M_Tnew > D_Tuse_rs)));
    stall_rt = (D_rt != 5'd0) &&
               (((E_A3 == D_rt) && (E_Tnew > D_Tuse_rt)) ||
                ((M_A3 == D_rt) && (M_Tnew > D_Tuse_rt)));
    stall_md = D_md && (E_start || busy);
  end

  always_comb begin
    stall   = stall_rs || stall_rt || stall_md;
    pc_en   = !stall;
    D_en    = !stall;
    E_flush = stall;
  end

  // Starts are only accepted when idle, so a busy unit never reloads or extends.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else if (E_start) begin
      cnt_d = E_div ? DivLoad : MultLoad;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy    = (cnt_q != 4'd0);
  assign md_done = (cnt_q == 4'd1);

endmodule

// File: tb/tb_stall_ctrl.sv
// Randomized and directed bench for stall_ctrl against a cycle-window reference model.
module tb_stall_ctrl;

  localparam int MultN = 5;
  localparam int DivN  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs, D_rt, E_A3, M_A3;
  logic [1:0] D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic       D_md, E_start, E_div;
  logic       stall, pc_en, D_en, E_flush, busy, md_done;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the unit is busy during cycles busy_from..busy_until (inclusive).
  int cyc        = 0;
  int busy_from  = 1;
  int busy_until = 0;

  stall_ctrl #(.MULT_CYCLES(MultN), .DIV_CYCLES(DivN)) dut (
    .clk      (clk),
    .reset    (reset),
    .D_rs     (D_rs),
    .D_rt     (D_rt),
    .D_Tuse_rs(D_Tuse_rs),
    .D_Tuse_rt(D_Tuse_rt),
    .D_md     (D_md),
    .E_A3     (E_A3),
    .E_Tnew   (E_Tnew),
    .M_A3     (M_A3),
    .M_Tnew   (M_Tnew),
    .E_start  (E_start),
    .E_div    (E_div),
    .stall    (stall),
    .pc_en    (pc_en),
    .D_en     (D_en),
    .E_flush  (E_flush),
    .busy     (busy),
    .md_done  (md_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit operand_waits(input int src, input int tuse);
    int a3[2];
    int tnew[2];
    a3[0] = int'(E_A3);   tnew[0] = int'(E_Tnew);
    a3[1] = int'(M_A3);   tnew[1] = int'(M_Tnew);
    if (src == 0) return 1'b0;
    foreach (a3[i]) begin
      if (a3[i] == src && tnew[i] > tuse) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit model_busy();
    return (cyc >= busy_from) && (cyc <= busy_until);
  endfunction

  task automatic clear_inputs();
    reset = 1'b0;
    D_rs = '0; D_rt = '0; E_A3 = '0; M_A3 = '0;
    D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3; E_Tnew = '0; M_Tnew = '0;
    D_md = 1'b0; E_start = 1'b0; E_div = 1'b0;
  endtask

  // Inputs are already applied; check this cycle, then advance through one clock edge.
  task automatic run_cycle();
    bit mb, exp_stall;
    #1;
    mb = model_busy();
    exp_stall = operand_waits(int'(D_rs), int'(D_Tuse_rs)) ||
                operand_waits(int'(D_rt), int'(D_Tuse_rt)) ||
                (D_md && (E_start || mb));
    check_eq("stall",   32'(stall),   32'(exp_stall));
    check_eq("pc_en",   32'(pc_en),   32'(!exp_stall));
    check_eq("D_en",    32'(D_en),    32'(!exp_stall));
    check_eq("E_flush", 32'(E_flush), 32'(exp_stall));
    check_eq("busy",    32'(busy),    32'(mb));
    check_eq("md_done", 32'(md_done), 32'(mb && cyc == busy_until));
    @(posedge clk);
    if (reset) begin
      busy_from  = 1;
      busy_until = 0;
    end else if (E_start && !mb) begin
      busy_from  = cyc + 1;
      busy_until = cyc + (E_div ? DivN : MultN);
    end
    cyc++;
    #1;
  endtask

  initial begin
    int n_busy, n_done;
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset held with quiet pipeline: combinational outputs still live.
    run_cycle();
    check_eq("rst_pc_en", 32'(pc_en), 32'd1);
    reset = 1'b0;

    // Producer in E not ready for an immediate consumer.
    D_rs = 5'd5; D_Tuse_rs = 2'd0; E_A3 = 5'd5; E_Tnew = 2'd1;
    #1 check_eq("raw_e_stall", 32'(stall), 32'd1);
    run_cycle();
    D_Tuse_rs = 2'd1;
    #1 check_eq("raw_e_ok", 32'(stall), 32'd0);
    run_cycle();

    // Register 0 never stalls.
    clear_inputs();
    D_rt = 5'd0; D_Tuse_rt = 2'd0; E_A3 = 5'd0; E_Tnew = 2'd2;
    #1 check_eq("r0_exempt", 32'(stall), 32'd0);
    run_cycle();

    // Multiply: busy exactly MultN cycles, one done pulse, stall while D_md.
    clear_inputs();
    D_md = 1'b1; E_start = 1'b1;
    run_cycle();
    E_start = 1'b0;
    n_busy = 0; n_done = 0;
    repeat (MultN + 2) begin
      n_busy += int'(busy);
      n_done += int'(md_done);
      run_cycle();
    end
    check_eq("mult_len",  32'(n_busy), 32'(MultN));
    check_eq("mult_done", 32'(n_done), 32'd1);

    // Divide with a second start mid-flight: no extension.
    clear_inputs();
    E_start = 1'b1; E_div = 1'b1;
    run_cycle();
    E_start = 1'b0;
    n_busy = 0;
    for (int i = 1; i <= DivN + 3; i++) begin
      E_start = (i == 3);
      n_busy += int'(busy);
      run_cycle();
    end
    check_eq("div_len", 32'(n_busy), 32'(DivN));

    // Divide abandoned by reset at busy cycle 4.
    clear_inputs();
    E_start = 1'b1; E_div = 1'b1;
    run_cycle();
    E_start = 1'b0;
    n_done = 0;
    repeat (3) begin
      n_done += int'(md_done);
      run_cycle();
    end
    reset = 1'b1;
    run_cycle();
    reset = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    repeat (DivN) begin
      n_done += int'(md_done);
      run_cycle();
    end
    check_eq("abort_done", 32'(n_done), 32'd0);

    // M-stage hazard overlapping an md stall, then both removed.
    clear_inputs();
    E_start = 1'b1;
    run_cycle();
    E_start = 1'b0;
    M_A3 = 5'd7; M_Tnew = 2'd1; D_rs = 5'd7; D_Tuse_rs = 2'd0; D_md = 1'b1;
    #1 check_eq("both_stall", 32'(stall), 32'd1);
    run_cycle();
    M_A3 = 5'd0; D_md = 1'b0;
    #1 check_eq("both_clear", 32'(stall), 32'd0);
    run_cycle();

    // Random traffic; small register range so hazards are frequent.
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 29) == 0);
      D_rs      = 5'($urandom_range(0, 3));
      D_rt      = 5'($urandom_range(0, 3));
      E_A3      = 5'($urandom_range(0, 3));
      M_A3      = 5'($urandom_range(0, 3));
      D_Tuse_rs = 2'($urandom_range(0, 3));
      D_Tuse_rt = 2'($urandom_range(0, 3));
      E_Tnew    = 2'($urandom_range(0, 3));
      M_Tnew    = 2'($urandom_range(0, 3));
      D_md      = ($urandom_range(0, 2) == 0);
      E_start   = ($urandom_range(0, 3) == 0);
      E_div     = 1'($urandom_range(0, 1));
      run_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, HI/LO busy cycles after a mult/multu start.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, HI/LO busy cycles after a div/divu start; both parameters SHALL be 1..15.
REQ-003 SHALL have one clock and a synchronous active-high reset: clk  input  1  rising-edge clock; reset  input  1  synchronous, active-high.
REQ-004 D_rs  input  5  D-stage rs field.
REQ-005 D_rt  input  5  D-stage rt field.
REQ-006 D_Tuse_rs  input  2  cycles until D-stage instr needs rs (3 = never).
REQ-007 D_Tuse_rt  input  2  cycles until D-stage instr needs rt (3 = never).
REQ-008 D_md  input  1  D-stage instr reads/writes HI/LO or starts mult/div.
REQ-009 E_A3  input  5  E-stage destination register.
REQ-010 E_Tnew  input  2  cycles until E-stage result is available.
REQ-011 M_A3  input  5  M-stage destination register.
REQ-012 M_Tnew  input  2  cycles until M-stage result is available.
REQ-013 E_start  input  1  E-stage instr is mult/multu/div/divu.
REQ-014 E_div  input  1  qualifies E_start: 1 = divide, 0 = multiply.
REQ-015 stall  output  1  pipeline stall request.
REQ-016 pc_en  output  1  PC write enable.
REQ-017 D_en  output  1  D-stage pipeline register write enable.
REQ-018 E_flush  output  1  E-stage pipeline register loads a bubble (all zero, pc/pc8 untouched by this block).
REQ-019 busy  output  1  HI/LO unit computing (registered).
REQ-020 md_done  output  1  one-cycle pulse, last busy cycle.

Function
REQ-021 stall_rs SHALL be 1 iff D_rs!=0 and ((E_A3==D_rs and E_Tnew>D_Tuse_rs) or (M_A3==D_rs and M_Tnew>D_Tuse_rs)); stall_rt SHALL be identical using D_rt, D_Tuse_rt.
REQ-022 stall_md SHALL be 1 iff D_md and (E_start or busy).
REQ-023 stall SHALL equal stall_rs or stall_rt or stall_md, combinationally from current inputs and registered busy.
REQ-024 pc_en and D_en SHALL equal not stall; E_flush SHALL equal stall; all zero-latency.
REQ-025 Register 0 SHALL never cause a stall, regardless of A3/Tnew values.
REQ-026 A 4-bit down-counter cnt SHALL hold remaining busy cycles; busy SHALL equal (cnt!=0).
REQ-027 When E_start=1 and busy=0 at a rising edge, cnt SHALL load DIV_CYCLES if E_div else MULT_CYCLES; busy rises the next cycle and stays high exactly that many cycles.
REQ-028 When cnt!=0, cnt SHALL decrement by 1 each cycle; E_start while busy SHALL be ignored (no reload, no extension).
REQ-029 md_done SHALL be 1 exactly in the cycle where cnt==1, and 0 otherwise.
REQ-030 Counter SHALL never wrap below 0.
REQ-031 Simultaneous stall_rs/rt and stall_md SHALL produce one stall; no priority is visible externally.

Reset
REQ-032 On a rising edge with reset=1, cnt SHALL become 0, so busy=0 and md_done=0 the next cycle; an in-progress mult/div SHALL be abandoned.
REQ-033 Reset SHALL take priority over E_start in the same cycle.
REQ-034 stall, pc_en, D_en, E_flush SHALL remain combinational during reset (with zero pipeline inputs: stall=0, pc_en=1, D_en=1, E_flush=0).

Verification
REQ-035 D_rs=5, D_Tuse_rs=0, E_A3=5, E_Tnew=1 -> stall=1, pc_en=0, D_en=0, E_flush=1; change D_Tuse_rs to 1 -> stall=0.
REQ-036 D_rt=0, E_A3=0, E_Tnew=2, D_Tuse_rt=0 -> stall=0 (register 0 exempt).
REQ-037 E_start=1, E_div=0 for one cycle -> busy=1 for exactly 5 cycles, md_done high on the 5th only; D_md=1 throughout -> stall=1 in the start cycle and in all 5 busy cycles, stall=0 in the following cycle.
REQ-038 E_start=1, E_div=1 -> busy for 10 cycles; second E_start at cycle 3 of busy -> busy still ends after 10 cycles total.
REQ-039 Div started, reset=1 at busy cycle 4 -> busy=0 and md_done=0 next cycle; no md_done pulse occurs.
REQ-040 M_A3=7, M_Tnew=1, D_rs=7, D_Tuse_rs=0 plus D_md=1 with busy=1 -> single stall=1; drop both conditions -> stall=0 the same cycle.
